fork_buffered_dataless: RTL and testbench

- Dataless eager fork with a token-counting input buffer: one input handshake channel is replicated to OUTPUTS output channels.
- Each output independently accepts a copy of every token. A token retires only after all outputs have taken it.
- The input side is decoupled by a SLOTS-deep token counter. Neither valid nor ready has a combinational path from input to outputs or back.
- Used as the split-side counterpart to the dataless merge in control networks, e.g. distributing start/done tokens.

---
 rtl/fork_buffered_dataless.sv | 75 +++++++
 tb/tb_fork_buffered_dataless.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fork_buffered_dataless.sv
// fork_buffered_dataless
// ---------------------------------------------------------------------------
// Dataless eager fork with a token-counting input buffer. Every token taken
// on the input channel is offered on all OUTPUTS output channels. Each output
// takes its copy independently. A token retires only once every output has
// taken it. Up to SLOTS tokens can be buffered.
//
// Handshake: a transfer happens on a channel in any cycle where valid and
// ready are both high at the rising clk edge. ins_ready and outs_valid are
// decoded from registered state only. Neither depends combinationally on
// ins_valid or outs_ready.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   ins_valid   input token offered
//   ins_ready   room for another token (count != SLOTS)
//   outs_valid  per-output token offered (head present, not yet taken here)
//   outs_ready  per-output consumer ready
// ---------------------------------------------------------------------------
module fork_buffered_dataless #(
    parameter int OUTPUTS = 2,
    parameter int SLOTS   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ins_valid,
    output logic               ins_ready,
    output logic [OUTPUTS-1:0] outs_valid,
    input  logic [OUTPUTS-1:0] outs_ready
);

    localparam int CW = $clog2(SLOTS + 1);
    localparam logic [CW-1:0] FULL = CW'(SLOTS);

    logic [CW-1:0]      count;
    logic [OUTPUTS-1:0] sent;
    logic [OUTPUTS-1:0] done;
    logic               head;
    logic               all_done;
    logic               in_acc;

    assign head       = (count != '0);
    assign ins_ready  = (count != FULL);
    assign outs_valid = head ? ~sent : '0;

    // An output is done with the head token if it already took it in an
    // earlier cycle or takes it this cycle.
    assign done     = sent | (outs_valid & outs_ready);
    assign all_done = head && (&done);
    assign in_acc   = ins_valid && ins_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent <= '0;
        end else if (all_done) begin
            sent <= '0;
        end else if (head) begin
            sent <= done;
        end
    end

    // ins_ready is low when full, so count cannot pass SLOTS. all_done needs
    // a head, so count cannot go below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (in_acc && !all_done) begin
            count <= count + CW'(1);
        end else if (!in_acc && all_done) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_fork_buffered_dataless.sv
module tb_fork_buffered_dataless;
    localparam int OUTPUTS = 2;
    localparam int SLOTS   = 2;
    localparam int W       = OUTPUTS + 1;

    logic               clk;
    logic               rst;
    logic               ins_valid;
    logic               ins_ready;
    logic [OUTPUTS-1:0] outs_valid;
    logic [OUTPUTS-1:0] outs_ready;

    fork_buffered_dataless #(.OUTPUTS(OUTPUTS), .SLOTS(SLOTS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // scoreboard: expected {ins_ready, outs_valid} per driven cycle
    logic [W-1:0] exp_q[$];

    // reference model: token ledger
    // m_acc  tokens accepted, m_ret tokens retired, m_del[i] tokens taken by output i
    int m_acc;
    int m_ret;
    int m_del[OUTPUTS];
    int tot_del[OUTPUTS];
    int obs_hs[OUTPUTS];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_ret = 0;
        for (int i = 0; i < OUTPUTS; i++) m_del[i] = 0;
    endtask

    // driver: one cycle of stimulus, expectation pushed, model advanced
    task automatic step(input logic v, input logic [OUTPUTS-1:0] r);
        logic [OUTPUTS-1:0] ev;
        logic               er;
        bit                 retire;
        ins_valid  = v;
        outs_ready = r;
        er = (m_acc - m_ret) < SLOTS;
        for (int i = 0; i < OUTPUTS; i++)
            ev[i] = (m_acc > m_ret) && (m_del[i] == m_ret);
        exp_q.push_back({er, ev});
        @(posedge clk);
        for (int i = 0; i < OUTPUTS; i++) begin
            if (ev[i] && r[i]) begin
                m_del[i]++;
                tot_del[i]++;
            end
        end
        retire = (m_acc > m_ret);
        for (int i = 0; i < OUTPUTS; i++)
            if (m_del[i] <= m_ret) retire = 0;
        if (retire) m_ret++;
        if (v && er) m_acc++;
        #1;
    endtask

    // monitor: compares DUT outputs with the scoreboard, counts handshakes
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            for (int i = 0; i < OUTPUTS; i++)
                if (outs_valid[i] && outs_ready[i]) obs_hs[i]++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ins_ready", int'(ins_ready), int'(e[W-1]));
                check("outs_valid", int'(outs_valid), int'(e[OUTPUTS-1:0]));
            end
        end
    end

    initial begin
        for (int i = 0; i < OUTPUTS; i++) begin
            tot_del[i] = 0;
            obs_hs[i]  = 0;
        end
        model_reset();
        ins_valid  = 1'b0;
        outs_ready = '0;
        rst        = 1'b1;
        #12;
        check("reset_outs_valid", int'(outs_valid), 0);
        check("reset_ins_ready", int'(ins_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // idle after reset
        for (int k = 0; k < 5; k++) step(1'b0, 2'b00);

        // streaming: 10 tokens back to back
        for (int k = 0; k < 10; k++) step(1'b1, 2'b11);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b11);

        // eager skew
        step(1'b1, 2'b00);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b01);
        step(1'b0, 2'b10);
        step(1'b0, 2'b00);

        // backpressure to full, then release
        for (int k = 0; k < 4; k++) step(1'b1, 2'b00);
        for (int k = 0; k < 4; k++) step(1'b0, 2'b11);

        // accept and retire when full
        step(1'b1, 2'b00);
        step(1'b1, 2'b00);
        step(1'b1, 2'b11);
        step(1'b1, 2'b00);
        for (int k = 0; k < 4; k++) step(1'b0, 2'b11);

        // reset mid-operation: full with output 0 already served
        step(1'b1, 2'b00);
        step(1'b1, 2'b00);
        step(1'b0, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outs_valid", int'(outs_valid), 0);
        check("midrst_ins_ready", int'(ins_ready), 1);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) step(1'b0, 2'b11);

        // random traffic
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), OUTPUTS'($urandom_range(0, (1 << OUTPUTS) - 1)));
        for (int k = 0; k < 6; k++) step(1'b0, 2'b11);

        @(negedge clk);
        #1;
        check("drain_empty", int'(outs_valid), 0);
        for (int i = 0; i < OUTPUTS; i++)
            check($sformatf("handshakes_out%0d", i), obs_hs[i], tot_del[i]);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
